// File: rtl/sys_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys_reset_pkg
//  Brief    : Shared types and constants for the system reset sequencer:
//             FSM encodings, reset-cause codes and the reset-count ceiling.
//  Revision : 1.0 - initial release
// ============================================================================
package sys_reset_pkg;

    // FSM encodings kept as plain 2-bit constants so legacy code and
    // register maps can reference the raw values.
    localparam logic [1:0] ST_HOLD         = 2'd0;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN          = 2'd2;

    typedef enum logic [1:0] {
        HOLD         = ST_HOLD,
        WAIT_RELEASE = ST_WAIT_RELEASE,
        RUN          = ST_RUN
    } state_t;

    // Cause of the most recent reset, as reported to software.
    typedef logic [1:0] cause_t;
    localparam cause_t CAUSE_POR = 2'b00;
    localparam cause_t CAUSE_BTN = 2'b01;
    localparam cause_t CAUSE_BRK = 2'b10;

    // Reset counter ceiling; the counter saturates here.
    localparam logic [7:0] RESET_COUNT_MAX = 8'hFF;

endpackage : sys_reset_pkg
`default_nettype wire

// File: rtl/sys_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sys_reset_sequencer_if
//  Brief    : Board-side reset sources and system-side reset/status bundle
//             of the system reset sequencer.
//             master : the sequencer (consumes sources, drives status)
//             slave  : the board / system block view
//  Revision : 1.0 - initial release
// ============================================================================
interface sys_reset_sequencer_if;
    import sys_reset_pkg::*;

    logic       btn_reset_n;   // raw pushbutton, active-low, asynchronous
    logic       uart_rxd;      // raw UART RX pin, tapped in parallel
    logic       sys_reset_n;   // registered active-low system reset
    cause_t     reset_cause;   // cause of the last reset
    logic [7:0] reset_count;   // button/break resets since power-on
    logic       break_active;  // UART break currently detected

    modport master (
        input  btn_reset_n,
        input  uart_rxd,
        output sys_reset_n,
        output reset_cause,
        output reset_count,
        output break_active
    );

    modport slave (
        output btn_reset_n,
        output uart_rxd,
        input  sys_reset_n,
        input  reset_cause,
        input  reset_count,
        input  break_active
    );

endinterface : sys_reset_sequencer_if
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sync_debounce
//  Brief    : Synchronizes an asynchronous active-low input, debounces it by
//             requiring DEBOUNCE_CYCLES consecutive differing samples before
//             accepting a new level, and emits a one-cycle registered pulse on
//             each debounced 1->0 transition.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_din,
    output logic o_level,
    output logic o_fall
);

    localparam int         c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_W-1:0]      r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchronizer chain; resets to the idle (released) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    // Debounce: count consecutive differing samples, flip on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
            r_level <= w_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered falling-edge detector on the debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_fall    <= r_level_d & ~r_level;
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule : sync_debounce
`default_nettype wire

// File: rtl/sys_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sys_reset_sequencer
//  Brief    : Reset conditioner for the system block. Merges power-on reset,
//             a debounced pushbutton and a UART break (long low on the raw
//             RX pin) into one registered active-low reset held for at least
//             HOLD_CYCLES, and reports the last cause plus a reset count.
//  Revision : 1.0 - initial release
// ============================================================================
module sys_reset_sequencer
    import sys_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BREAK_CYCLES    = 10000000,
    parameter int HOLD_CYCLES     = 65536
) (
    input  wire                   clkin,
    input  wire                   reset_n,
    sys_reset_sequencer_if.master bus
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_BRK_W  = $clog2(BREAK_CYCLES + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_BRK_W-1:0]  c_BRK_MAX   = c_BRK_W'(BREAK_CYCLES);

    // ------------------------------------------------------------------------
    // Internal reset: asserts with reset_n, releases SYNC_STAGES edges later
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic                   w_rst_n;

    // Reset release synchronizer; every other flop resets from its output.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Pushbutton: synchronize, debounce, falling-edge pulse
    // ------------------------------------------------------------------------
    logic w_btn_level;
    logic w_btn_event;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clkin),
        .rst_n   (w_rst_n),
        .i_din   (bus.btn_reset_n),
        .o_level (w_btn_level),
        .o_fall  (w_btn_event)
    );

    // ------------------------------------------------------------------------
    // UART break detector
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rxd_sync;
    logic                   w_rxd;
    logic [c_BRK_W-1:0]     r_brk_cnt;
    logic                   r_break_active;
    logic                   r_break_active_d;
    logic                   r_brk_event;

    assign w_rxd = r_rxd_sync[SYNC_STAGES-1];

    // RX pin synchronizer; idles high like a UART line.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rxd_sync <= '1;
        end else begin
            r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], bus.uart_rxd};
        end
    end

    // Low-time counter: saturates at the break threshold, any high clears it.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_brk_cnt <= '0;
        end else if (w_rxd) begin
            r_brk_cnt <= '0;
        end else if (r_brk_cnt != c_BRK_MAX) begin
            r_brk_cnt <= r_brk_cnt + 1'b1;
        end
    end

    // Break flag and its rising-edge pulse; a long break yields one event.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_break_active   <= 1'b0;
            r_break_active_d <= 1'b0;
            r_brk_event      <= 1'b0;
        end else begin
            r_break_active   <= (r_brk_cnt == c_BRK_MAX);
            r_break_active_d <= r_break_active;
            r_brk_event      <= r_break_active & ~r_break_active_d;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencing FSM, hold counter and status registers
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_sys_reset_n;
    cause_t                r_reset_cause;
    logic [7:0]            r_reset_count;
    logic                  w_hold_term;
    logic                  w_source_active;
    logic                  w_any_event;

    assign w_hold_term     = (r_hold_cnt == c_HOLD_LAST);
    assign w_source_active = ~w_btn_level | r_break_active;
    assign w_any_event     = w_btn_event | r_brk_event;

    // Next-state decode; events outside RUN are deliberately ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HOLD: begin
                if (w_hold_term) begin
                    w_state_next = w_source_active ? WAIT_RELEASE : RUN;
                end
            end
            WAIT_RELEASE: begin
                if (!w_source_active) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_any_event) begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = HOLD;
        endcase
    end

    // State, hold timer, registered reset output and cause/count capture.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= HOLD;
            r_hold_cnt    <= '0;
            r_sys_reset_n <= 1'b0;
            r_reset_cause <= CAUSE_POR;
            r_reset_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_sys_reset_n <= (w_state_next == RUN);
            if (r_state == RUN) begin
                // Keep the timer parked at zero so HOLD always starts fresh.
                r_hold_cnt <= '0;
                if (w_any_event) begin
                    // Button wins when both events land on the same cycle.
                    r_reset_cause <= w_btn_event ? CAUSE_BTN : CAUSE_BRK;
                    if (r_reset_count != RESET_COUNT_MAX) begin
                        r_reset_count <= r_reset_count + 8'd1;
                    end
                end
            end else if ((r_state == HOLD) && !w_hold_term) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign bus.sys_reset_n  = r_sys_reset_n;
    assign bus.reset_cause  = r_reset_cause;
    assign bus.reset_count  = r_reset_count;
    assign bus.break_active = r_break_active;

endmodule : sys_reset_sequencer
`default_nettype wire

// File: tb/tb_sys_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_reset_sequencer
//  Brief    : Self-checking bench for sys_reset_sequencer with small timing
//             parameters. Table of {inputs, cycles, expected outputs} records
//             for POR/button/break, then hand sequences for simultaneous
//             events, count saturation and asynchronous reset in HOLD.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sys_reset_sequencer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int BREAK_CYCLES    = 16;
    localparam int HOLD_CYCLES     = 8;

    logic clkin = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    sys_reset_sequencer_if bus_if ();

    sys_reset_sequencer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BREAK_CYCLES    (BREAK_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES)
    ) dut (
        .clkin   (clkin),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic       btn;
        logic       rxd;
        int         cycles;
        logic       sys;
        logic [1:0] cause;
        logic [7:0] count;
        logic       brk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic btn, input logic rxd, input int cycles,
                                input logic sys, input logic [1:0] cause,
                                input logic [7:0] count, input logic brk);
        vec_t v;
        v.btn = btn; v.rxd = rxd; v.cycles = cycles;
        v.sys = sys; v.cause = cause; v.count = count; v.brk = brk;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int idx, input logic sys,
                             input logic [1:0] cause, input logic [7:0] count,
                             input logic brk);
        check({name, ".sys_reset_n"},  idx, {7'd0, bus_if.sys_reset_n},  {7'd0, sys});
        check({name, ".reset_cause"},  idx, {6'd0, bus_if.reset_cause},  {6'd0, cause});
        check({name, ".reset_count"},  idx, bus_if.reset_count,          count);
        check({name, ".break_active"}, idx, {7'd0, bus_if.break_active}, {7'd0, brk});
    endtask

    // Bounded wait for sys_reset_n to reach a level; timeout is a failure.
    task automatic wait_sys(input logic val, input int budget, input string name, input int idx);
        int n;
        n = 0;
        while ((bus_if.sys_reset_n !== val) && (n < budget)) begin
            tick();
            n++;
        end
        check(name, idx, {7'd0, bus_if.sys_reset_n}, {7'd0, val});
    endtask

    task automatic btn_reset(input int idx);
        bus_if.btn_reset_n = 1'b0;
        wait_sys(1'b0, 40, "btn_press_fall", idx);
        bus_if.btn_reset_n = 1'b1;
        wait_sys(1'b1, 60, "btn_release_rise", idx);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;

        reset_n            = 1'b0;
        bus_if.btn_reset_n = 1'b1;
        bus_if.uart_rxd    = 1'b1;

        // POR: 10 edges low after release
        add(1, 1,  9, 0, 2'd0, 8'd0, 0);
        add(1, 1,  1, 1, 2'd0, 8'd0, 0);
        // Button: 3-cycle glitch ignored, then a long press
        add(0, 1,  3, 1, 2'd0, 8'd0, 0);
        add(1, 1,  8, 1, 2'd0, 8'd0, 0);
        add(0, 1,  7, 1, 2'd0, 8'd0, 0);
        add(0, 1,  1, 0, 2'd1, 8'd1, 0);
        add(0, 1, 12, 0, 2'd1, 8'd1, 0);
        add(1, 1,  6, 0, 2'd1, 8'd1, 0);
        add(1, 1,  1, 1, 2'd1, 8'd1, 0);
        // Break: 15-cycle low ignored, then a 40-cycle break
        add(1, 0, 15, 1, 2'd1, 8'd1, 0);
        add(1, 1,  5, 1, 2'd1, 8'd1, 0);
        add(1, 0, 18, 1, 2'd1, 8'd1, 0);
        add(1, 0,  1, 1, 2'd1, 8'd1, 1);
        add(1, 0,  1, 1, 2'd1, 8'd1, 1);
        add(1, 0,  1, 0, 2'd2, 8'd2, 1);
        add(1, 0, 19, 0, 2'd2, 8'd2, 1);
        add(1, 1,  3, 0, 2'd2, 8'd2, 1);
        add(1, 1,  1, 0, 2'd2, 8'd2, 0);
        add(1, 1,  1, 1, 2'd2, 8'd2, 0);

        repeat (5) tick();
        check_all("reset_state", 0, 1'b0, 2'd0, 8'd0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus_if.btn_reset_n = vecs[i].btn;
            bus_if.uart_rxd    = vecs[i].rxd;
            repeat (vecs[i].cycles) tick();
            check_all("vec", i, vecs[i].sys, vecs[i].cause, vecs[i].count, vecs[i].brk);
        end

        // Simultaneous: break active and button debounce finish on one edge
        bus_if.uart_rxd = 1'b0;
        repeat (13) tick();
        bus_if.btn_reset_n = 1'b0;
        repeat (7) tick();
        check_all("simul_pre", 0, 1'b1, 2'd0 + 2'd2, 8'd2, 1'b1);
        tick();
        check_all("simul_hit", 0, 1'b0, 2'd1, 8'd3, 1'b1);
        bus_if.btn_reset_n = 1'b1;
        bus_if.uart_rxd    = 1'b1;
        wait_sys(1'b1, 60, "simul_release", 0);
        check_all("simul_after", 0, 1'b1, 2'd1, 8'd3, 1'b0);

        // Saturation: count climbs from 3 and sticks at 255
        for (int i = 1; i <= 260; i++) begin
            btn_reset(i);
            exp_cnt = (3 + i > 255) ? 255 : 3 + i;
            check("sat_count", i, bus_if.reset_count, exp_cnt[7:0]);
        end
        check("sat_cause", 0, {6'd0, bus_if.reset_cause}, 8'd1);

        // Asynchronous reset in the middle of HOLD
        bus_if.btn_reset_n = 1'b0;
        wait_sys(1'b0, 40, "async_enter_hold", 0);
        repeat (2) tick();
        bus_if.btn_reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_clear", 0, 1'b0, 2'd0, 8'd0, 1'b0);
        repeat (5) tick();
        reset_n = 1'b1;
        repeat (9) tick();
        check_all("async_por_hold", 0, 1'b0, 2'd0, 8'd0, 1'b0);
        tick();
        check_all("async_por_run", 0, 1'b1, 2'd0, 8'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sys_reset_sequencer
`default_nettype wire
